matrix_alu_2x2: RTL and testbench

MATRIX_ALU_2X2 -- requirements
Module: matrix_alu_2x2

---
 rtl/matrix_alu_2x2.sv | 155 +++++++++++++++
 tb/tb_matrix_alu_2x2.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_alu_2x2.sv
// ---------------------------------------------------------------------------
// matrix_alu_2x2
//
// Purpose:
//   2x2 matrix ALU for unsigned W-bit elements. It supports three operations.
//   - Add: all four elements are computed in one RUN cycle.
//   - Subtract: all four elements are computed in one RUN cycle.
//   - Multiply: eight RUN cycles, using one W x W multiplier and one
//     RW-bit accumulator.
//   Operands and op are latched when start is accepted in IDLE.
//
// Configuration:
//   MATRIX_ALU_ERR_EN - when defined, the err output and reserved-op checking
//                       are compiled in. op=11 then goes straight to DONE with
//                       c=0 and err=1. When the macro is undefined, there is
//                       no err port and op=11 executes as add.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request pulse; sampled only in IDLE
//   op    - 00 add, 01 subtract, 10 multiply, 11 reserved
//   a, b  - operand matrices packed {x11,x12,x21,x22}, x11 in the MSBs
//   c     - result matrix packed {c11,c12,c21,c22}
//   busy  - high in RUN and DONE
//   done  - one-cycle pulse when c is valid
//   err   - reserved-op flag (MATRIX_ALU_ERR_EN only)
// ---------------------------------------------------------------------------
module matrix_alu_2x2 #(
    parameter int W  = 4,
    parameter int RW = 2*W+1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [4*W-1:0]  a,
    input  logic [4*W-1:0]  b,
    output logic [4*RW-1:0] c,
    output logic            busy,
    output logic            done
`ifdef MATRIX_ALU_ERR_EN
    ,
    output logic            err
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_RSV} op_t;

    state_t          state_q, state_d;
    op_t             op_q;
    logic [4*W-1:0]  a_q, b_q;
    logic [2:0]      cnt_q;
    logic [RW-1:0]   acc_q;
    logic [RW-1:0]   c_q [4];

    logic [W-1:0]    a_el [4];
    logic [W-1:0]    b_el [4];
    logic [W:0]      sum_el [4];
    logic [W:0]      diff_el [4];
    logic [W-1:0]    mul_a, mul_b;
    logic [2*W-1:0]  prod;
    logic [RW-1:0]   prod_ext;
    logic            reserved_op;

`ifdef MATRIX_ALU_ERR_EN
    assign reserved_op = (op == OP_RSV);
`else
    assign reserved_op = 1'b0;
`endif

    // Element index 0..3 maps to x11, x12, x21, x22.
    // The index 2*row+col therefore selects an element.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_el[i]    = a_q[(3-i)*W +: W];
            b_el[i]    = b_q[(3-i)*W +: W];
            sum_el[i]  = {1'b0, a_el[i]} + {1'b0, b_el[i]};
            diff_el[i] = {1'b0, a_el[i]} - {1'b0, b_el[i]};
        end
    end

    // Multiply step k: element (i,j) = (k[2],k[1]), product term t = k[0].
    // The step multiplies a[i][t] by b[t][j].
    assign mul_a    = a_el[{cnt_q[2], cnt_q[0]}];
    assign mul_b    = b_el[{cnt_q[0], cnt_q[1]}];
    assign prod     = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    assign prod_ext = {{(RW-2*W){1'b0}}, prod};

    // NOTE: every variable written in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = reserved_op ? DONE : RUN;
            RUN:  if (op_q != OP_MUL || cnt_q == 3'd7) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_ADD;
            cnt_q <= '0;
            acc_q <= '0;
            // NOTE: the result array drives a visible output, so it is reset
            // explicitly. It is only four registers, not a RAM macro.
            for (int i = 0; i < 4; i++) c_q[i] <= '0;
        end else if (state_q == IDLE && start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op_t'(op);
            cnt_q <= '0;
            acc_q <= '0;
            for (int i = 0; i < 4; i++) c_q[i] <= '0;
        end else if (state_q == RUN) begin
            if (op_q == OP_MUL) begin
                if (!cnt_q[0]) begin
                    acc_q <= prod_ext;
                end else begin
                    c_q[cnt_q[2:1]] <= acc_q + prod_ext;
                    acc_q           <= '0;
                end
                // Hold on the last step; DONE follows, so the counter never wraps.
                if (cnt_q != 3'd7) cnt_q <= cnt_q + 3'd1;
            end else if (op_q == OP_SUB) begin
                for (int i = 0; i < 4; i++)
                    c_q[i] <= {{(RW-W-1){diff_el[i][W]}}, diff_el[i]};
            end else begin
                for (int i = 0; i < 4; i++)
                    c_q[i] <= {{(RW-W-1){1'b0}}, sum_el[i]};
            end
        end
    end

    assign c    = {c_q[0], c_q[1], c_q[2], c_q[3]};
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

`ifdef MATRIX_ALU_ERR_EN
    assign err  = (state_q == DONE) && (op_q == OP_RSV);
`endif

endmodule

// File: tb/tb_matrix_alu_2x2.sv
// ---------------------------------------------------------------------------
// tb_matrix_alu_2x2
//
// Directed vectors with hand-computed expectations for matrix_alu_2x2 (W=4).
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at
// that point.
// Latency counts clock edges from the edge that accepts start to the first
// cycle with done=1.
// ---------------------------------------------------------------------------
module tb_matrix_alu_2x2;

    localparam int W  = 4;
    localparam int RW = 2*W+1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      op;
    logic [4*W-1:0]  a, b;
    logic [4*RW-1:0] c;
    logic            busy, done;
`ifdef MATRIX_ALU_ERR_EN
    logic            err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    matrix_alu_2x2 #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done)
`ifdef MATRIX_ALU_ERR_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge. Return c right after acceptance and the latency
    // to done. The wait is bounded to 20 edges.
    task automatic run_op(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                          output int lat, output logic [35:0] c_first);
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start   = 1'b0;
        c_first = c;
        lat     = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    int             lat;
    int             pulses;
    logic [35:0]    c_first;

    initial begin
        rst = 1'b1; start = 1'b1; op = 2'b10; a = 16'h2345; b = 16'h1234;

        // Reset with start held high: start must be ignored.
        tick(); tick();
        rst = 1'b0; start = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_c",    c,    36'd0);
        tick();
        check("rst_start_ignored", busy, 1'b0);

        // Add: [2 3;4 5] + [1 2;3 4] = [3 5 7 9], latency 2.
        run_op(2'b00, 16'h2345, 16'h1234, lat, c_first);
        check("add_lat", lat, 2);
        check("add_c",   c, {9'd3, 9'd5, 9'd7, 9'd9});
        check("add_busy_in_done", busy, 1'b1);
`ifdef MATRIX_ALU_ERR_EN
        check("add_err", err, 1'b0);
`endif
        tick();
        check("add_done_one_cycle", done, 1'b0);
        check("add_idle_busy", busy, 1'b0);
        check("add_c_hold", c, {9'd3, 9'd5, 9'd7, 9'd9});

        // Subtract: same operands give all ones.
        run_op(2'b01, 16'h2345, 16'h1234, lat, c_first);
        check("sub_lat", lat, 2);
        check("sub_c",   c, {9'd1, 9'd1, 9'd1, 9'd1});
        tick();

        // Subtract: 1-3 gives -2, sign-extended to 9'h1FE.
        run_op(2'b01, 16'h1000, 16'h3000, lat, c_first);
        check("sub_neg_c", c, {9'h1FE, 9'd0, 9'd0, 9'd0});
        tick();

        // Multiply: [2 3;4 5]*[1 2;3 4] = [11 16 19 28], latency 9.
        // c is cleared on acceptance.
        run_op(2'b10, 16'h2345, 16'h1234, lat, c_first);
        check("mul_c_cleared", c_first, 36'd0);
        check("mul_lat", lat, 9);
        check("mul_c",   c, {9'd11, 9'd16, 9'd19, 9'd28});
        tick();
        check("mul_done_one_cycle", done, 1'b0);

        // Multiply of all-15 operands: every element is 2*225 = 450.
        run_op(2'b10, 16'hFFFF, 16'hFFFF, lat, c_first);
        check("mul_max_lat", lat, 9);
        check("mul_max_c", c, {9'd450, 9'd450, 9'd450, 9'd450});
        tick();

        // Second start during a multiply, with operands changed mid-RUN.
        // start stays high through DONE, which must also be ignored.
        op = 2'b10; a = 16'h2345; b = 16'h1234; start = 1'b1;
        tick();
        a = 16'hFFFF; b = 16'hFFFF; op = 2'b00;
        lat = 1; pulses = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        if (done) pulses++;
        check("restart_lat", lat, 9);
        check("restart_c", c, {9'd11, 9'd16, 9'd19, 9'd28});
        tick();
        start = 1'b0;
        check("start_in_done_ignored", busy, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            tick();
        end
        check("restart_one_done", pulses, 1);
        check("restart_c_hold", c, {9'd11, 9'd16, 9'd19, 9'd28});

        // Reset at multiply step 4. c11 and c12 are already written.
        op = 2'b10; a = 16'h2345; b = 16'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mul_partial_c", c[35:18], {9'd11, 9'd16});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_c",    c,    36'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            tick();
        end
        check("abort_no_done", pulses, 0);
        run_op(2'b00, 16'h2345, 16'h1234, lat, c_first);
        check("post_abort_add_lat", lat, 2);
        check("post_abort_add_c", c, {9'd3, 9'd5, 9'd7, 9'd9});
        tick();

        // Reserved op.
        run_op(2'b11, 16'h2345, 16'h1234, lat, c_first);
`ifdef MATRIX_ALU_ERR_EN
        check("rsv_lat", lat, 1);
        check("rsv_err", err, 1'b1);
        check("rsv_c",   c,   36'd0);
        tick();
        check("rsv_err_clear", err, 1'b0);
`else
        check("rsv_as_add_lat", lat, 2);
        check("rsv_as_add_c", c, {9'd3, 9'd5, 9'd7, 9'd9});
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
